buffer_loader: RTL and testbench

BUFFER_LOADER -- requirements
Module: buffer_loader

---
 rtl/buffer_loader.sv | 145 ++++++++++++++
 tb/tb_buffer_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_loader.sv
// buffer_loader: packs pairs of 16-bit elements into 32-bit bank stores and streams the banks out.
// Optional macro BUFFER_LOADER_ODD_PAD_EN zero-pads a dangling half element instead of raising err.
module buffer_loader #(
    parameter int ARR_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        stream_req,
    output logic [31:0] buf_data,
    output logic [7:0]  buf_addr,
    output logic [1:0]  buf_state,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, PAD, STREAM, DONE} state_t;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_STORE  = 2'b01;
    localparam logic [1:0] CMD_STREAM = 2'b10;
    localparam logic [8:0] SIZE       = 9'(ARR_SIZE);
    localparam logic [7:0] LAST_RD    = 8'(ARR_SIZE - 1);

    state_t      state_q, state_d;
    logic [8:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic        half_q, half_d;
    logic [15:0] low_q, low_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        err_q, err_d;
    logic        accept;

    assign in_ready = (state_q == IDLE) && (wr_ptr_q < SIZE) && !stream_req;
    assign accept   = in_valid && in_ready;

    // Command outputs are registered: whatever is decided here appears on the bus next cycle.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        half_d   = half_q;
        low_d    = low_q;
        err_d    = err_q;
        cmd_d    = CMD_NOP;
        data_d   = 32'h0;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (stream_req) begin
                    if (half_q) begin
`ifdef BUFFER_LOADER_ODD_PAD_EN
                        state_d  = PAD;
                        cmd_d    = CMD_STORE;
                        data_d   = {16'h0000, low_q};
                        addr_d   = wr_ptr_q[7:0];
                        wr_ptr_d = wr_ptr_q + 9'd2;
                        half_d   = 1'b0;
`else
                        state_d = STREAM;
                        cmd_d   = CMD_STREAM;
                        addr_d  = rd_ptr_q;
                        half_d  = 1'b0;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = STREAM;
                        cmd_d   = CMD_STREAM;
                        addr_d  = rd_ptr_q;
                    end
                end else if (accept) begin
                    if (!half_q) begin
                        low_d  = in_data;
                        half_d = 1'b1;
                    end else begin
                        cmd_d    = CMD_STORE;
                        data_d   = {in_data, low_q};
                        addr_d   = wr_ptr_q[7:0];
                        wr_ptr_d = wr_ptr_q + 9'd2;
                        half_d   = 1'b0;
                    end
                end
            end
            PAD: begin
                state_d = STREAM;
                cmd_d   = CMD_STREAM;
                addr_d  = rd_ptr_q;
            end
            STREAM: begin
                // rd_ptr_q always equals the address currently shown on the bus.
                if (rd_ptr_q == LAST_RD) begin
                    state_d  = DONE;
                    rd_ptr_d = 8'd0;
                    wr_ptr_d = 9'd0;
                    half_d   = 1'b0;
                end else begin
                    rd_ptr_d = rd_ptr_q + 8'd1;
                    cmd_d    = CMD_STREAM;
                    addr_d   = rd_ptr_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= 9'd0;
            rd_ptr_q <= 8'd0;
            half_q   <= 1'b0;
            cmd_q    <= CMD_NOP;
            data_q   <= 32'h0;
            addr_q   <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            half_q   <= half_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        low_q <= low_d;
    end

    assign buf_data  = data_q;
    assign buf_addr  = addr_q;
    assign buf_state = cmd_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_buffer_loader.sv
// Self-checking bench for buffer_loader (ARR_SIZE=4) with randomized element data and gaps.
module tb_buffer_loader;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        stream_req;
    logic [31:0] buf_data;
    logic [7:0]  buf_addr;
    logic [1:0]  buf_state;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    buffer_loader #(.ARR_SIZE(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stream_req(stream_req),
        .buf_data(buf_data), .buf_addr(buf_addr), .buf_state(buf_state),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; stream_req = 1'b0; in_data = 16'h0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({buf_state, buf_data, buf_addr, busy, done, err, in_ready} !== {2'b00, 32'h0, 8'h0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got st=%b d=%h a=%h busy=%b done=%b err=%b rdy=%b required all 0 rdy=1",
                     buf_state, buf_data, buf_addr, busy, done, err, in_ready);
        end
    endtask

    // Fill all banks with randomly spaced elements, hold off an extra one, then stream.
    task automatic test_fill_and_stream();
        int          wr;
        logic [7:0]  last_addr;
        logic [15:0] low;
        logic [15:0] d;
        wr = 0; last_addr = 8'h0; low = 16'h0;
        for (int k = 0; k < N; k++) begin
            d = (k == 0) ? 16'h1111 : (k == 1) ? 16'h2222 : 16'($urandom);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_before_elem%0d got %b required 1", k, in_ready);
            end
            in_valid = 1'b1; in_data = d;
            step();
            in_valid = 1'b0;
            if (k % 2 == 0) begin
                low = d;
                checks++;
                if (buf_state !== 2'b00) begin
                    errors++;
                    $display("FAIL no_store_after_first%0d got %b required 00", k, buf_state);
                end
            end else begin
                checks++;
                if ({buf_state, buf_addr, buf_data} !== {2'b01, 8'(wr), d, low}) begin
                    errors++;
                    $display("FAIL store_pair%0d got st=%b a=%h d=%h required st=01 a=%h d=%h",
                             k, buf_state, buf_addr, buf_data, 8'(wr), {d, low});
                end
                last_addr = 8'(wr);
                wr += 2;
            end
            repeat ($urandom_range(0, 2)) begin
                step();
                checks++;
                if ({buf_state, buf_data, buf_addr} !== {2'b00, 32'h0, last_addr}) begin
                    errors++;
                    $display("FAIL idle_gap got st=%b d=%h a=%h required st=00 d=0 a=%h",
                             buf_state, buf_data, buf_addr, last_addr);
                end
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b required 0", in_ready);
        end
        in_valid = 1'b1; in_data = 16'($urandom);
        repeat (3) begin
            step();
            checks++;
            if ({buf_state, in_ready} !== {2'b00, 1'b0}) begin
                errors++;
                $display("FAIL fifth_held_off got st=%b rdy=%b required st=00 rdy=0", buf_state, in_ready);
            end
        end
        stream_req = 1'b1;
        step();
        stream_req = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({buf_state, buf_addr, buf_data, busy, done} !== {2'b10, 8'(i), 32'h0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stream_cycle%0d got st=%b a=%h d=%h busy=%b done=%b required st=10 a=%h",
                         i, buf_state, buf_addr, buf_data, busy, done, 8'(i));
            end
            step();
        end
        checks++;
        if ({done, busy, buf_state, buf_addr} !== {1'b1, 1'b1, 2'b00, 8'(N - 1)}) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b st=%b a=%h required done=1 busy=1 st=00 a=%h",
                     done, busy, buf_state, buf_addr, 8'(N - 1));
        end
        step();
        checks++;
        if ({done, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL back_to_idle got done=%b busy=%b rdy=%b required 0 0 1", done, busy, in_ready);
        end
    endtask

    task automatic test_odd_count();
        logic exp_err;
`ifdef BUFFER_LOADER_ODD_PAD_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        do_reset();
        in_valid = 1'b1; in_data = 16'hABCD;
        step();
        in_valid = 1'b0;
        stream_req = 1'b1;
        step();
        stream_req = 1'b0;
`ifdef BUFFER_LOADER_ODD_PAD_EN
        checks++;
        if ({buf_state, buf_addr, buf_data, busy} !== {2'b01, 8'h00, 32'h0000ABCD, 1'b1}) begin
            errors++;
            $display("FAIL pad_store got st=%b a=%h d=%h busy=%b required st=01 a=00 d=0000abcd busy=1",
                     buf_state, buf_addr, buf_data, busy);
        end
        step();
`endif
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({buf_state, buf_addr, buf_data, err} !== {2'b10, 8'(i), 32'h0, exp_err}) begin
                errors++;
                $display("FAIL odd_stream%0d got st=%b a=%h d=%h err=%b required st=10 a=%h err=%b",
                         i, buf_state, buf_addr, buf_data, err, 8'(i), exp_err);
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL odd_done got %b required 1", done);
        end
        step();
        step();
        checks++;
        if ({err, busy} !== {exp_err, 1'b0}) begin
            errors++;
            $display("FAIL err_sticky got err=%b busy=%b required err=%b busy=0", err, busy, exp_err);
        end
    endtask

    task automatic test_contention();
        logic [15:0] a;
        logic [15:0] b;
        do_reset();
        in_valid = 1'b1; in_data = 16'($urandom); stream_req = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL contend_ready got %b required 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            stream_req = (i < 2);
            #1;
            checks++;
            if ({buf_state, buf_addr, buf_data} !== {2'b10, 8'(i), 32'h0}) begin
                errors++;
                $display("FAIL contend_stream%0d got st=%b a=%h d=%h required st=10 a=%h d=0",
                         i, buf_state, buf_addr, buf_data, 8'(i));
            end
            step();
        end
        stream_req = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL contend_done got %b required 1", done);
        end
        step();
        step();
        checks++;
        if ({buf_state, busy} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL req_ignored got st=%b busy=%b required st=00 busy=0", buf_state, busy);
        end
        a = 16'($urandom); b = 16'($urandom);
        in_valid = 1'b1; in_data = a;
        step();
        in_data = b;
        step();
        in_valid = 1'b0;
        checks++;
        if ({buf_state, buf_addr, buf_data} !== {2'b01, 8'h00, b, a}) begin
            errors++;
            $display("FAIL post_stream_store got st=%b a=%h d=%h required st=01 a=00 d=%h",
                     buf_state, buf_addr, buf_data, {b, a});
        end
        stream_req = 1'b1;
        step();
        stream_req = 1'b0;
        step();
        checks++;
        if ({buf_state, buf_addr} !== {2'b10, 8'h01}) begin
            errors++;
            $display("FAIL second_stream_cycle got st=%b a=%h required st=10 a=01", buf_state, buf_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({buf_state, busy, done} !== {2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_on_rst got st=%b busy=%b done=%b required 00 0 0", buf_state, busy, done);
        end
        for (int i = 0; i < N + 2; i++) begin
            step();
            checks++;
            if ({buf_state, done} !== {2'b00, 1'b0}) begin
                errors++;
                $display("FAIL after_abort%0d got st=%b done=%b required st=00 done=0", i, buf_state, done);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; stream_req = 1'b0; in_data = 16'h0;
        test_reset();
        test_fill_and_stream();
        test_odd_count();
        test_contention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
